// File: rtl/mem_read_checker.sv
// Settings shared with the transaction generator, and the read-data checker.
// The checker matches queued transaction descriptors to Avalon-MM read beats,
// compares the enabled bytes against the expected pattern and latches the
// first mismatch for the CSR block.

package rtl_settings_pkg;
    localparam int AMM_DATA_W  = 512;
    localparam int DATA_B_W    = AMM_DATA_W / 8;
    localparam int ADDR_B_W    = $clog2(DATA_B_W);
    localparam int ADDR_W      = 32;
    localparam int AMM_BURST_W = 11;
    localparam     ADDR_TYPE   = "BYTE";

    typedef enum logic { FIX_DATA = 1'b0, RND_DATA = 1'b1 } data_mode_t;

    typedef struct packed {
        logic                   trans_type;   // 1 = write, 0 = read
        logic [ADDR_W-1:0]      start_addr;
        logic [AMM_BURST_W-1:0] words_count;  // beats - 1
        logic [ADDR_B_W-1:0]    start_off;
        logic [ADDR_B_W-1:0]    end_off;
        data_mode_t             data_mode;
        logic [7:0]             data_ptrn;
    } cmp_struct_t;

    // Enabled bytes of a beat: the first beat starts at start_off, the last ends at end_off
    function automatic logic [DATA_B_W-1:0] byteenable_ptrn(
        input logic                start_enable,
        input logic                end_enable,
        input logic [ADDR_B_W-1:0] start_off,
        input logic [ADDR_B_W-1:0] end_off
    );
        logic [DATA_B_W-1:0] m;
        for (int i = 0; i < DATA_B_W; i++)
            m[i] = (!start_enable || (ADDR_B_W'(i) >= start_off)) &&
                   (!end_enable   || (ADDR_B_W'(i) <= end_off));
        return m;
    endfunction

    // One bit per enabled byte lane whose data differs from the expected byte
    function automatic logic [DATA_B_W-1:0] check_vector(
        input logic [AMM_DATA_W-1:0] data,
        input logic [7:0]            exp_byte,
        input logic [DATA_B_W-1:0]   mask
    );
        logic [DATA_B_W-1:0] v;
        for (int i = 0; i < DATA_B_W; i++)
            v[i] = mask[i] && (data[8*i +: 8] != exp_byte);
        return v;
    endfunction

    // Index of the lowest failing byte lane
    function automatic logic [ADDR_B_W-1:0] err_byte(input logic [DATA_B_W-1:0] vec);
        logic [ADDR_B_W-1:0] idx;
        idx = '0;
        for (int i = DATA_B_W - 1; i >= 0; i--)
            if (vec[i]) idx = ADDR_B_W'(i);
        return idx;
    endfunction

    // Galois LFSR step, taps 8'hB8
    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {1'b0, x[7:1]} ^ (x[0] ? 8'hB8 : 8'h00);
    endfunction
endpackage

module mem_read_checker
    import rtl_settings_pkg::*;
#(
    parameter int CMP_FIFO_DEPTH = 8,
    parameter int CNT_W          = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  test_start_i,
    input  cmp_struct_t           cmp_struct_i,
    input  logic                  cmp_valid_i,
    output logic                  cmp_ready_o,
    input  logic                  readdatavalid_i,
    input  logic [AMM_DATA_W-1:0] readdata_i,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [ADDR_W-1:0]     err_addr_o,
    output logic [7:0]            err_data_o,
    output logic                  unexp_o,
    output logic [CNT_W-1:0]      rd_words_o
);
    localparam int PTR_W = $clog2(CMP_FIFO_DEPTH);

    cmp_struct_t            fifo_mem [CMP_FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr, rd_ptr;
    logic                   empty, full, push, pop;
    cmp_struct_t            head;
    logic                   head_rd, last_beat;
    logic [AMM_BURST_W-1:0] beat_k;
    logic [7:0]             lfsr_q, exp_byte;
    logic [DATA_B_W-1:0]    beat_mask;
    logic [ADDR_W-1:0]      beat_addr;

    // vld_pipe[0]: checked beat this cycle, [1]: S1 registers, [2]: S2 result
    logic [2:0]             vld_pipe;

    logic [AMM_DATA_W-1:0]  s1_data;
    logic [DATA_B_W-1:0]    s1_mask;
    logic [7:0]             s1_exp;
    logic [ADDR_W-1:0]      s1_addr;
    logic [DATA_B_W-1:0]    s2_vec;
    logic [ADDR_B_W-1:0]    s2_byte;
    logic [ADDR_W-1:0]      err_addr_nxt;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head        = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign cmp_ready_o = !rst_i && !full;
    assign push        = cmp_valid_i && cmp_ready_o;

    // A beat is only checked against a read descriptor already sitting at the head
    assign head_rd     = !empty && !head.trans_type;
    assign vld_pipe[0] = readdatavalid_i && head_rd;
    assign last_beat   = (beat_k == head.words_count);
    assign pop         = !empty && (head.trans_type || (vld_pipe[0] && last_beat));

    assign exp_byte  = (head.data_mode == RND_DATA && beat_k != '0) ? lfsr_q : head.data_ptrn;
    assign beat_mask = byteenable_ptrn(beat_k == '0, last_beat, head.start_off, head.end_off);

    assign s2_vec  = check_vector(s1_data, s1_exp, s1_mask);
    assign s2_byte = err_byte(s2_vec);

    generate
        if (ADDR_TYPE == "WORD") begin : g_word_addr
            assign beat_addr    = head.start_addr + ADDR_W'(beat_k);
            assign err_addr_nxt = s1_addr;
        end else begin : g_byte_addr
            // Advance the word part by k and drop the in-word offset; the failing
            // byte index is filled in once S2 knows it
            assign beat_addr    = (head.start_addr + (ADDR_W'(beat_k) << ADDR_B_W)) &
                                  ~ADDR_W'(DATA_B_W - 1);
            assign err_addr_nxt = s1_addr | ADDR_W'(s2_byte);
        end
    endgenerate

    assign busy_o = !empty || vld_pipe[1] || vld_pipe[2];

    // FIFO pointers; a descriptor accepted during test_start lands in a fresh FIFO
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (test_start_i) begin
            wr_ptr <= {{PTR_W{1'b0}}, push};
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[test_start_i ? '0 : wr_ptr[PTR_W-1:0]] <= cmp_struct_i;
    end

    // Beat position within the head burst and running LFSR value
    always_ff @(posedge clk_i) begin
        if (rst_i || test_start_i) begin
            beat_k <= '0;
            lfsr_q <= '0;
        end else if (vld_pipe[0]) begin
            beat_k <= last_beat ? '0 : beat_k + 1'b1;
            lfsr_q <= lfsr_step(exp_byte);
        end
    end

    // Pipeline valid shift register
    always_ff @(posedge clk_i) begin
        if (rst_i || test_start_i) vld_pipe[2:1] <= '0;
        else                       vld_pipe[2:1] <= vld_pipe[1:0];
    end

    // S1 capture of the beat and its expected value
    always_ff @(posedge clk_i) begin
        if (vld_pipe[0]) begin
            s1_data <= readdata_i;
            s1_mask <= beat_mask;
            s1_exp  <= exp_byte;
            s1_addr <= beat_addr;
        end
    end

    // S2: latch only the first mismatch since the last clear
    always_ff @(posedge clk_i) begin
        if (rst_i || test_start_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
            err_data_o <= '0;
        end else if (vld_pipe[1] && (|s2_vec) && !err_o) begin
            err_o      <= 1'b1;
            err_addr_o <= err_addr_nxt;
            err_data_o <= s1_data[{s2_byte, 3'b000} +: 8];
        end
    end

    // Sticky unexpected-beat flag and saturating beat counter
    always_ff @(posedge clk_i) begin
        if (rst_i || test_start_i) begin
            unexp_o    <= 1'b0;
            rd_words_o <= '0;
        end else if (readdatavalid_i) begin
            if (!head_rd)          unexp_o    <= 1'b1;
            if (rd_words_o != '1)  rd_words_o <= rd_words_o + 1'b1;
        end
    end
endmodule
